// File: rtl/wshb_pkg.sv
// rtl/wshb_pkg.sv - Wishbone B4 cycle/burst type codes shared by master and slave
package wshb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        LINEAR = 2'b00
    } bte_t;

endpackage

// File: rtl/wshb_ram_slave_mem.sv
// rtl/wshb_ram_slave_mem.sv - single-port synchronous frame RAM, byte write enables
module wshb_ram_slave_mem #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // rdata only moves on a read access, so it holds across writes and idle cycles
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (wbe == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wshb_ram_slave.sv
// rtl/wshb_ram_slave.sv - Wishbone B4 frame-memory responder with burst prefetch
module wshb_ram_slave
    import wshb_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    output logic [31:0] dat_sm,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic        ack,
    output logic        err
);

    localparam int          AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] TOP = 32'(MEM_WORDS);
    localparam logic [2:0]  LAT = 3'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

    state_t        state, state_nx;
    logic [2:0]    cnt, cnt_nx;
    logic [29:0]   word_r, word_nx;
    logic          bad_r, bad_nx;
    logic [29:0]   adr_word;
    logic [30:0]   word_inc;
    logic          req, incr, bte_bad, req_bad, inc_bad, wr_ok, beat;
    logic          ack_r, err_r;
    logic          mem_en;
    logic [3:0]    mem_wbe;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_q, dat_hold;
    logic          unused_adr;

    assign unused_adr = ^adr[1:0];
    assign adr_word   = adr[31:2];
    assign req        = cyc & stb;
    assign incr       = (cti == INCR);
    assign bte_bad    = incr && (bte != LINEAR);
    assign word_inc   = {1'b0, word_r} + 31'd1;
    // error status of a beat is decided one cycle early so ack/err come from flops
    assign req_bad    = ({2'b00, adr_word} >= TOP) || bte_bad;
    assign inc_bad    = ({1'b0, word_inc} >= TOP) || bte_bad;
    assign wr_ok      = ({2'b00, adr_word} < TOP);
    assign beat       = req && (state == ACK || state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            word_r <= 30'd0;
            bad_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            word_r <= word_nx;
            bad_r  <= bad_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        word_nx  = word_r;
        bad_nx   = bad_r;
        case (state)
            IDLE: begin
                if (req) begin
                    word_nx  = adr_word;
                    bad_nx   = req_bad;
                    cnt_nx   = LAT;
                    state_nx = (LAT == 3'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_nx = IDLE;
                end else if (cnt <= 3'd1) begin
                    cnt_nx   = 3'd0;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            ACK, BURST: begin
                if (!req || bad_r || !incr) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = BURST;
                    word_nx  = word_inc[29:0];
                    bad_nx   = inc_bad;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack_r    = 1'b0;
        err_r    = 1'b0;
        mem_en   = 1'b0;
        mem_wbe  = 4'b0000;
        mem_addr = adr_word[AW-1:0];
        case (state)
            IDLE: begin
                mem_en = req && !req_bad && !we;
            end
            ACK, BURST: begin
                ack_r = !bad_r;
                err_r = bad_r;
                if (beat && !bad_r) begin
                    if (we) begin
                        mem_en  = wr_ok;
                        mem_wbe = wr_ok ? sel : 4'b0000;
                    end else if (incr && !inc_bad) begin
                        // prefetch so the next burst beat is ready one clock later
                        mem_en   = 1'b1;
                        mem_addr = word_inc[AW-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_hold <= 32'd0;
        end else if (ack) begin
            dat_hold <= mem_q;
        end
    end

    assign ack    = ack_r & req;
    assign err    = err_r & req;
    assign dat_sm = ack ? mem_q : dat_hold;

    wshb_ram_slave_mem #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .wbe   (mem_wbe),
        .addr  (mem_addr),
        .wdata (dat_ms),
        .rdata (mem_q)
    );

endmodule

// File: tb/tb_wshb_ram_slave.sv
// tb/tb_wshb_ram_slave.sv - scoreboard bench for the Wishbone frame-memory responder
module tb_wshb_ram_slave;
    import wshb_pkg::*;

    localparam int LAT       = 1;
    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_ms = 32'd0;
    logic [31:0] dat_sm;
    logic [3:0]  sel = 4'd0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = 3'd0;
    logic [1:0]  bte = 2'd0;
    logic        ack;
    logic        err;

    wshb_ram_slave #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .adr    (adr),
        .dat_ms (dat_ms),
        .dat_sm (dat_sm),
        .sel    (sel),
        .we     (we),
        .cyc    (cyc),
        .stb    (stb),
        .cti    (cti),
        .bte    (bte),
        .ack    (ack),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          cyc;
        bit          is_err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cycle);
    endtask

    function automatic logic [31:0] mem_val(input int w);
        if (w == 'h40) return 32'hA5A5_A5A5;
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    task automatic sb_push(input int c, input bit is_err, input bit chk, input logic [31:0] d);
        sbq.push_back('{c, is_err, chk, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; cti = CLASSIC;
    endtask

    task automatic classic(input bit w, input int word, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] c, input bit exp_err, input logic [31:0] exp_d);
        step();
        cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(word) << 2; dat_ms = d; sel = s; cti = c;
        sb_push(cycle + LAT + 1, exp_err, !w, exp_d);
        repeat (LAT + 1) step();
        step();
        idle();
    endtask

    task automatic burst(input int base, input int n, input bit eob, input int err_at);
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'd0;
        adr = 32'(base) << 2;
        cti = (n == 1 && eob) ? EOB : INCR;
        repeat (LAT + 1) step();
        for (int i = 0; i < n; i++) begin
            adr = 32'(base + i) << 2;
            cti = (i == n - 1 && eob) ? EOB : INCR;
            sb_push(cycle, i == err_at, i < err_at, mem_val(base + i));
            step();
        end
        if (eob) idle();
        else stb = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ack || err) begin
            check("ack_err_excl", {31'b0, ack & err}, 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_resp", {31'b0, ack | err}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("resp_cycle", 32'(cycle), 32'(e.cyc));
                check("resp_err", {31'b0, err}, {31'b0, e.is_err});
                if (e.chk && !e.is_err) check("rdata", dat_sm, e.data);
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", {31'b0, ack}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_dat", dat_sm, 32'd0);
        cyc = 1'b1; stb = 1'b1;
        #1;
        check("reset_ack_req", {31'b0, ack}, 32'd0);
        check("reset_err_req", {31'b0, err}, 32'd0);
        idle();
        rst_n = 1'b1;

        // preload over the bus
        classic(1, 0, mem_val(0), 4'hF, CLASSIC, 0, 0);
        for (int w = 'h40; w <= 'h47; w++) classic(1, w, mem_val(w), 4'hF, CLASSIC, 0, 0);
        classic(1, MEM_WORDS - 2, mem_val(MEM_WORDS - 2), 4'hF, CLASSIC, 0, 0);
        classic(1, MEM_WORDS - 1, mem_val(MEM_WORDS - 1), 4'hF, CLASSIC, 0, 0);
        classic(1, 'h80, 32'd0, 4'hF, CLASSIC, 0, 0);

        classic(0, 'h40, 0, 4'h0, CLASSIC, 0, 32'hA5A5_A5A5);

        classic(1, 'h80, 32'h1122_3344, 4'b0101, CLASSIC, 0, 0);
        classic(0, 'h80, 0, 4'h0, CLASSIC, 0, 32'h0022_0044);

        burst('h40, 8, 1, 99);
        classic(0, 'h47, 0, 4'h0, CLASSIC, 0, mem_val('h47));

        burst('h40, 3, 0, 99);
        burst('h43, 5, 1, 99);

        classic(0, MEM_WORDS, 0, 4'h0, CLASSIC, 1, 0);
        classic(1, MEM_WORDS, 32'hDEAD_BEEF, 4'hF, CLASSIC, 1, 0);
        classic(0, 0, 0, 4'h0, CLASSIC, 0, mem_val(0));
        burst(MEM_WORDS - 2, 3, 1, 2);
        classic(0, MEM_WORDS - 1, 0, 4'h0, CLASSIC, 0, mem_val(MEM_WORDS - 1));

        bte = 2'b01;
        classic(0, 'h40, 0, 4'h0, INCR, 1, 0);
        bte = 2'b00;

        // reset while the third beat of a burst is being acked
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; cti = INCR;
        repeat (LAT + 1) step();
        sb_push(cycle, 0, 1, mem_val('h40));
        step();
        adr = 32'h104;
        sb_push(cycle, 0, 1, mem_val('h41));
        step();
        adr = 32'h108;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, ack}, 32'd0);
        check("midrst_err", {31'b0, err}, 32'd0);
        check("midrst_dat", dat_sm, 32'd0);
        step();
        idle();
        rst_n = 1'b1;
        classic(0, 'h41, 0, 4'h0, CLASSIC, 0, mem_val('h41));

        repeat (3) step();
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
